// File: rtl/wave_capture.sv
// wave_capture: writer side of the two-bank waveform display buffer.
//
// ADC samples are decimated (keep 1 of every decim+1 valid samples), watched
// for a level/slope trigger (with a forced trigger after AUTO_TIMEOUT accepted
// samples in auto mode), and SAMPLES consecutive points are written into the
// back bank of the wave RAM. The displayed bank flips only on a frame start,
// so the LCD reader never sees a half-written trace.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active low
//   adc_data[7:0]  unsigned ADC sample, qualified by adc_valid
//   run            capture enable; 0 stops/aborts the current capture
//   trig_mode[1:0] 00 auto, 01 normal, 10 single, 11 normal
//   trig_slope     0 rising, 1 falling
//   trig_level     trigger threshold
//   decim          decimation ratio minus one
//   frame_sync     LCD vsync level (asynchronous); falling edge = frame start
//   wave_ram_we    one-cycle write strobe
//   wave_ram_add   {bank, point index}
//   wave_ram_data  sample written
//   show_bank      bank the reader displays
//   capt_busy      high while waiting for a trigger or capturing
//   trig_seen      the current trace has triggered
//   trig_auto      the current trace was force-triggered
module wave_capture #(
  parameter int SAMPLES      = 480,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  input  logic       run,
  input  logic [1:0] trig_mode,
  input  logic       trig_slope,
  input  logic [7:0] trig_level,
  input  logic [7:0] decim,
  input  logic       frame_sync,
  output logic       wave_ram_we,
  output logic [9:0] wave_ram_add,
  output logic [7:0] wave_ram_data,
  output logic       show_bank,
  output logic       capt_busy,
  output logic       trig_seen,
  output logic       trig_auto
);

  localparam int           AW        = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [8:0]   LAST_IDX  = 9'(SAMPLES - 1);
  localparam logic [AW-1:0] AUTO_MAX  = AW'(AUTO_TIMEOUT);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    CAPTURE   = 3'd2,
    PEND_SWAP = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t        state;
  logic          fs_p0, fs_p1, fs_p2;
  logic [7:0]    dec_cnt;
  logic [7:0]    dec_lim;
  logic [AW-1:0] auto_cnt;
  logic [7:0]    prev_smp;
  logic          prev_vld;
  logic [8:0]    idx;

  // Saturating increment of the auto-trigger sample counter.
  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
    return (v >= AUTO_MAX) ? AUTO_MAX : v + AW'(1);
  endfunction

  // Next decimation count: wraps to 0 once the latched limit is reached.
  function automatic logic [7:0] dec_next(input logic [7:0] cnt, input logic [7:0] lim);
    return (cnt >= lim) ? 8'd0 : cnt + 8'd1;
  endfunction

  // ---- stage p0: sample acceptance and trigger decision (combinational) ----
  logic       acc_p0;
  logic       dec_wrap_p0;
  logic       mode_auto, mode_single;
  logic       cross_rise, cross_fall;
  logic       trig_hit_p0, auto_hit_p0;
  logic       fs_fall;
  logic [8:0] idx_nxt;

  assign acc_p0      = adc_valid && (dec_cnt == 8'd0);
  assign dec_wrap_p0 = adc_valid && (dec_cnt >= dec_lim);
  assign mode_auto   = (trig_mode == 2'b00);
  assign mode_single = (trig_mode == 2'b10);
  assign cross_rise  = (prev_smp < trig_level) && (adc_data >= trig_level);
  assign cross_fall  = (prev_smp > trig_level) && (adc_data <= trig_level);
  assign trig_hit_p0 = prev_vld && (trig_slope ? cross_fall : cross_rise);
  // auto_cnt holds the number of earlier untriggered samples, so this is the
  // AUTO_TIMEOUT-th one when the count has reached AUTO_TIMEOUT-1.
  assign auto_hit_p0 = mode_auto && (auto_cnt >= AUTO_LAST);
  // fs_p2 lags fs_p1 by one clock: 1 then 0 marks the synchronized fall.
  assign fs_fall     = fs_p2 && !fs_p1;
  assign idx_nxt     = idx + 9'd1;

  // ---- stage p1: registered RAM write, FSM and bookkeeping ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      fs_p0         <= 1'b0;
      fs_p1         <= 1'b0;
      fs_p2         <= 1'b0;
      dec_cnt       <= 8'd0;
      dec_lim       <= 8'd0;
      auto_cnt      <= '0;
      prev_smp      <= 8'd0;
      prev_vld      <= 1'b0;
      idx           <= 9'd0;
      wave_ram_we   <= 1'b0;
      wave_ram_add  <= 10'd0;
      wave_ram_data <= 8'd0;
      show_bank     <= 1'b0;
      capt_busy     <= 1'b0;
      trig_seen     <= 1'b0;
      trig_auto     <= 1'b0;
    end else begin
      fs_p0       <= frame_sync;
      fs_p1       <= fs_p0;
      fs_p2       <= fs_p1;
      wave_ram_we <= 1'b0;

      // The limit is re-latched only at a wrap, so a new decim value
      // never cuts the current decimation period short.
      if (adc_valid) begin
        dec_cnt <= dec_next(dec_cnt, dec_lim);
        if (dec_wrap_p0) dec_lim <= decim;
      end

      case (state)
        IDLE: begin
          if (run) begin
            state     <= WAIT_TRIG;
            capt_busy <= 1'b1;
            dec_cnt   <= 8'd0;
            dec_lim   <= decim;
            auto_cnt  <= '0;
            prev_vld  <= 1'b0;
            idx       <= 9'd0;
            trig_seen <= 1'b0;
            trig_auto <= 1'b0;
          end
        end

        WAIT_TRIG: begin
          if (!run) begin
            state     <= IDLE;
            capt_busy <= 1'b0;
          end else if (acc_p0) begin
            prev_smp <= adc_data;
            prev_vld <= 1'b1;
            if (trig_hit_p0 || auto_hit_p0) begin
              state         <= CAPTURE;
              idx           <= 9'd0;
              wave_ram_we   <= 1'b1;
              wave_ram_add  <= {~show_bank, 9'd0};
              wave_ram_data <= adc_data;
              trig_seen     <= 1'b1;
              trig_auto     <= !trig_hit_p0;
              auto_cnt      <= '0;
            end else begin
              auto_cnt <= sat_inc(auto_cnt);
            end
          end
        end

        CAPTURE: begin
          if (!run) begin
            state     <= IDLE;
            capt_busy <= 1'b0;
          end else if (acc_p0) begin
            idx           <= idx_nxt;
            wave_ram_we   <= 1'b1;
            wave_ram_add  <= {~show_bank, idx_nxt};
            wave_ram_data <= adc_data;
            if (idx_nxt == LAST_IDX) begin
              state     <= PEND_SWAP;
              capt_busy <= 1'b0;
            end
          end
        end

        // The final write is issued on entry, so it always lands before
        // any swap taken here.
        PEND_SWAP: begin
          if (fs_fall) begin
            show_bank <= ~show_bank;
            if (mode_single) begin
              state <= HOLD;
            end else if (run) begin
              state     <= WAIT_TRIG;
              capt_busy <= 1'b1;
              dec_cnt   <= 8'd0;
              dec_lim   <= decim;
              auto_cnt  <= '0;
              prev_vld  <= 1'b0;
              idx       <= 9'd0;
              trig_seen <= 1'b0;
              trig_auto <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end

        HOLD: begin
          if (!run) state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          capt_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
module tb_wave_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       run;
  logic [1:0] trig_mode;
  logic       trig_slope;
  logic [7:0] trig_level;
  logic [7:0] decim;
  logic       frame_sync;
  logic       wave_ram_we;
  logic [9:0] wave_ram_add;
  logic [7:0] wave_ram_data;
  logic       show_bank;
  logic       capt_busy;
  logic       trig_seen;
  logic       trig_auto;

  wave_capture #(.SAMPLES(480), .AUTO_TIMEOUT(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .run          (run),
    .trig_mode    (trig_mode),
    .trig_slope   (trig_slope),
    .trig_level   (trig_level),
    .decim        (decim),
    .frame_sync   (frame_sync),
    .wave_ram_we  (wave_ram_we),
    .wave_ram_add (wave_ram_add),
    .wave_ram_data(wave_ram_data),
    .show_bank    (show_bank),
    .capt_busy    (capt_busy),
    .trig_seen    (trig_seen),
    .trig_auto    (trig_auto)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log, captured on the falling edge.
  logic [9:0] wr_add  [0:4095];
  logic [7:0] wr_data [0:4095];
  int         wr_cyc  [0:4095];
  int         wr_cnt = 0;
  always @(negedge clk) begin
    if (wave_ram_we === 1'b1 && wr_cnt < 4096) begin
      wr_add[wr_cnt]  <= wave_ram_add;
      wr_data[wr_cnt] <= wave_ram_data;
      wr_cyc[wr_cnt]  <= cyc;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  int         n_chk  = 0;
  int         n_pass = 0;
  logic       ramp_on;
  logic [7:0] ramp_step;

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp_on) adc_data = adc_data + ramp_step;
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; frame_sync = 1'b1; ramp_on = 1'b0; ramp_step = 8'd1;
    adc_valid = 1'b0; adc_data = 8'd0; trig_mode = 2'b00; trig_slope = 1'b0;
    trig_level = 8'h80; decim = 8'd0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b1; adc_valid = 1'b1; adc_data = 8'hAA; frame_sync = 1'b0;
    ramp_on = 1'b0; ramp_step = 8'd1; trig_mode = 2'b00; trig_slope = 1'b0;
    trig_level = 8'h10; decim = 8'd0;
    repeat (3) tick();
    n_chk++;
    if ({wave_ram_we, wave_ram_add, wave_ram_data, show_bank, capt_busy, trig_seen, trig_auto} !== 23'd0)
      $display("FAIL reset_outputs got we=%b add=%h data=%h bank=%b busy=%b seen=%b auto=%b want all 0",
               wave_ram_we, wave_ram_add, wave_ram_data, show_bank, capt_busy, trig_seen, trig_auto);
    else n_pass++;
    run = 1'b0; rst = 1'b1;
    tick();
    n_chk++;
    if (capt_busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", capt_busy);
    else n_pass++;
  endtask

  // Auto mode, constant input: forced trigger on the 1024th sample, then swap.
  task automatic test_auto_timeout();
    int base, c0, bad, first;
    do_reset();
    trig_mode = 2'b00; decim = 8'd0; adc_data = 8'h40; adc_valid = 1'b1;
    base = wr_cnt; c0 = cyc; run = 1'b1;
    repeat (1560) tick();
    n_chk++;
    if (wr_cnt - base !== 480) $display("FAIL auto_count got %0d want 480", wr_cnt - base);
    else n_pass++;
    n_chk++;
    if (wr_cyc[base] !== c0 + 1025) $display("FAIL auto_first_cycle got %0d want %0d", wr_cyc[base] - c0, 1025);
    else n_pass++;
    bad = 0; first = 0;
    for (int i = 0; i < 480; i++) begin
      if (wr_add[base+i] !== 10'(32'h200 + i) || wr_data[base+i] !== 8'h40) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    n_chk++;
    if (bad != 0) $display("FAIL auto_trace idx %0d got add=%h data=%h want add=%h data=40 (%0d bad)",
                           first, wr_add[base+first], wr_data[base+first], 10'(32'h200 + first), bad);
    else n_pass++;
    n_chk++;
    if ({trig_seen, trig_auto, capt_busy, show_bank} !== 4'b1100)
      $display("FAIL auto_flags got seen=%b auto=%b busy=%b bank=%b want 1 1 0 0",
               trig_seen, trig_auto, capt_busy, show_bank);
    else n_pass++;
    frame_sync = 1'b0;
    tick(); tick();
    n_chk++;
    if (show_bank !== 1'b0) $display("FAIL auto_swap_early got bank=%b want 0", show_bank);
    else n_pass++;
    tick();
    n_chk++;
    if (show_bank !== 1'b1 || capt_busy !== 1'b1)
      $display("FAIL auto_swap got bank=%b busy=%b want 1 1", show_bank, capt_busy);
    else n_pass++;
    run = 1'b0; frame_sync = 1'b1;
    tick();
  endtask

  // Normal mode, rising ramp through 0x80.
  task automatic test_normal_ramp();
    int base, c0, bad, first;
    do_reset();
    trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 8'h80; decim = 8'd0;
    adc_valid = 1'b1; adc_data = 8'h00; ramp_step = 8'd1; ramp_on = 1'b1;
    base = wr_cnt; c0 = cyc; run = 1'b1;
    repeat (128) tick();
    n_chk++;
    if (wr_cnt - base !== 0) $display("FAIL normal_prewrite got %0d writes want 0", wr_cnt - base);
    else n_pass++;
    repeat (500) tick();
    n_chk++;
    if (wr_cnt - base !== 480) $display("FAIL normal_count got %0d want 480", wr_cnt - base);
    else n_pass++;
    n_chk++;
    if (wr_cyc[base] !== c0 + 129 || wr_data[base] !== 8'h80 || wr_add[base] !== 10'h200)
      $display("FAIL normal_first got cyc=%0d add=%h data=%h want cyc=129 add=200 data=80",
               wr_cyc[base] - c0, wr_add[base], wr_data[base]);
    else n_pass++;
    n_chk++;
    if (wr_data[base+479] !== 8'h5F || wr_add[base+479] !== 10'h3DF)
      $display("FAIL normal_last got add=%h data=%h want add=3df data=5f", wr_add[base+479], wr_data[base+479]);
    else n_pass++;
    bad = 0; first = 0;
    for (int i = 0; i < 480; i++) begin
      if (wr_add[base+i] !== 10'(32'h200 + i) || wr_data[base+i] !== 8'(32'h80 + i)) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    n_chk++;
    if (bad != 0) $display("FAIL normal_trace idx %0d got add=%h data=%h want add=%h data=%h",
                           first, wr_add[base+first], wr_data[base+first], 10'(32'h200 + first), 8'(32'h80 + first));
    else n_pass++;
    n_chk++;
    if (trig_seen !== 1'b1 || trig_auto !== 1'b0)
      $display("FAIL normal_flags got seen=%b auto=%b want 1 0", trig_seen, trig_auto);
    else n_pass++;
  endtask

  // decim=3: every 4th valid sample, writes 4 cycles apart.
  task automatic test_decimation();
    int base, c0, bad, first;
    do_reset();
    trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 8'h80; decim = 8'd3;
    adc_valid = 1'b1; adc_data = 8'h00; ramp_step = 8'd1; ramp_on = 1'b1;
    base = wr_cnt; c0 = cyc; run = 1'b1;
    repeat (200) tick();
    n_chk++;
    if (wr_cnt - base !== 18) $display("FAIL decim_count got %0d want 18", wr_cnt - base);
    else n_pass++;
    bad = 0; first = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_data[base+i] !== 8'(32'h81 + 4*i) || wr_add[base+i] !== 10'(32'h200 + i) ||
          wr_cyc[base+i] !== c0 + 130 + 4*i) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    n_chk++;
    if (bad != 0) $display("FAIL decim_trace idx %0d got cyc=%0d add=%h data=%h want cyc=%0d add=%h data=%h",
                           first, wr_cyc[base+first] - c0, wr_add[base+first], wr_data[base+first],
                           130 + 4*first, 10'(32'h200 + first), 8'(32'h81 + 4*first));
    else n_pass++;
  endtask

  // run dropped right after index 200 is accepted.
  task automatic test_abort();
    int base;
    do_reset();
    trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 8'h80; decim = 8'd0;
    adc_valid = 1'b1; adc_data = 8'h00; ramp_step = 8'd1; ramp_on = 1'b1;
    base = wr_cnt; run = 1'b1;
    repeat (329) tick();
    run = 1'b0;
    tick();
    n_chk++;
    if (capt_busy !== 1'b0) $display("FAIL abort_busy got %b want 0", capt_busy);
    else n_pass++;
    frame_sync = 1'b0;
    repeat (40) tick();
    n_chk++;
    if (wr_cnt - base !== 201) $display("FAIL abort_count got %0d want 201", wr_cnt - base);
    else n_pass++;
    n_chk++;
    if (wr_add[base+200] !== 10'h2C8 || wr_data[base+200] !== 8'h48)
      $display("FAIL abort_last got add=%h data=%h want add=2c8 data=48", wr_add[base+200], wr_data[base+200]);
    else n_pass++;
    n_chk++;
    if (show_bank !== 1'b0) $display("FAIL abort_bank got %b want 0", show_bank);
    else n_pass++;
    frame_sync = 1'b1;
  endtask

  // Single mode, falling slope: one trace, one swap, then HOLD.
  task automatic test_single();
    int base, bad, first;
    do_reset();
    trig_mode = 2'b10; trig_slope = 1'b1; trig_level = 8'h80; decim = 8'd0;
    adc_valid = 1'b1; adc_data = 8'hFF; ramp_step = 8'hFF; ramp_on = 1'b1;
    base = wr_cnt; run = 1'b1;
    repeat (620) tick();
    bad = 0; first = 0;
    for (int i = 0; i < 480; i++) begin
      if (wr_add[base+i] !== 10'(32'h200 + i) || wr_data[base+i] !== 8'(32'h80 - i)) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    n_chk++;
    if (bad != 0) $display("FAIL single_trace idx %0d got add=%h data=%h want add=%h data=%h",
                           first, wr_add[base+first], wr_data[base+first], 10'(32'h200 + first), 8'(32'h80 - first));
    else n_pass++;
    frame_sync = 1'b0;
    repeat (3) tick();
    frame_sync = 1'b1;
    n_chk++;
    if (show_bank !== 1'b1 || capt_busy !== 1'b0)
      $display("FAIL single_swap got bank=%b busy=%b want 1 0", show_bank, capt_busy);
    else n_pass++;
    repeat (1100) tick();
    frame_sync = 1'b0;
    repeat (5) tick();
    n_chk++;
    if (wr_cnt - base !== 480 || show_bank !== 1'b1)
      $display("FAIL single_hold got writes=%0d bank=%b want 480 1", wr_cnt - base, show_bank);
    else n_pass++;
    frame_sync = 1'b1;
    run = 1'b0;
    tick();
    n_chk++;
    if (capt_busy !== 1'b0) $display("FAIL single_idle got busy=%b want 0", capt_busy);
    else n_pass++;
    run = 1'b1;
    tick();
    n_chk++;
    if (capt_busy !== 1'b1 || trig_seen !== 1'b0)
      $display("FAIL single_rearm got busy=%b seen=%b want 1 0", capt_busy, trig_seen);
    else n_pass++;
  endtask

  // Second trace goes to bank 0; reset lands in the middle of it.
  task automatic test_reset_mid_capture();
    int base, base2, n_before;
    do_reset();
    trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 8'h80; decim = 8'd0;
    adc_valid = 1'b1; adc_data = 8'h00; ramp_step = 8'd1; ramp_on = 1'b1;
    base = wr_cnt; run = 1'b1;
    repeat (620) tick();
    frame_sync = 1'b0;
    repeat (3) tick();
    frame_sync = 1'b1;
    base2 = wr_cnt;
    repeat (60) tick();
    n_chk++;
    if (base2 - base !== 480 || wr_cnt - base2 < 10 || wr_add[base2] !== 10'h000 || wr_data[base2] !== 8'h80)
      $display("FAIL second_trace got first=%0d second=%0d add=%h data=%h want 480 >=10 add=000 data=80",
               base2 - base, wr_cnt - base2, wr_add[base2], wr_data[base2]);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_before = wr_cnt;
    n_chk++;
    if ({wave_ram_we, wave_ram_add, wave_ram_data, show_bank, capt_busy, trig_seen, trig_auto} !== 23'd0)
      $display("FAIL midreset_outputs got we=%b add=%h data=%h bank=%b busy=%b seen=%b auto=%b want all 0",
               wave_ram_we, wave_ram_add, wave_ram_data, show_bank, capt_busy, trig_seen, trig_auto);
    else n_pass++;
    repeat (3) tick();
    n_chk++;
    if (wr_cnt !== n_before) $display("FAIL midreset_nowrite got %0d writes want 0", wr_cnt - n_before);
    else n_pass++;
    rst = 1'b1; run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_auto_timeout();
    test_normal_ramp();
    test_decimation();
    test_abort();
    test_single();
    test_reset_mid_capture();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
